// File: rtl/mau_controller_pkg.sv
// Shared definitions for the MAU host-side controller: command op codes,
// memory target codes, controller FSM states and a target-to-strobe helper.
// Imported by mau_controller and mau_run_timer. The cpu top-level bench can
// import the same package so both agree on the encodings.
package mau_controller_pkg;

    // Host command op codes (cmd_op)
    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_READ   = 2'd1,
        OP_RUN    = 2'd2,
        OP_STATUS = 2'd3
    } op_e;

    // Memory targets for WRITE/READ (cmd_target)
    typedef enum logic [1:0] {
        TGT_IM      = 2'd0,
        TGT_DM      = 2'd1,
        TGT_RF      = 2'd2,
        TGT_INVALID = 2'd3
    } target_e;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RUN   = 3'd3,
        ST_RSP   = 3'd4
    } state_e;

    // One-hot write strobes {rf, dm, im} for a target; invalid target gives none
    function automatic logic [2:0] target_wren(input logic [1:0] target);
        logic [2:0] wren;
        wren = 3'b000;
        case (target)
            TGT_IM:  wren = 3'b001;
            TGT_DM:  wren = 3'b010;
            TGT_RF:  wren = 3'b100;
            default: wren = 3'b000;
        endcase
        return wren;
    endfunction

endpackage

// File: rtl/mau_run_timer.sv
// Alive-cycle counter used while the CPU runs.
// Ports:
//   clk, rst        clock and synchronous active-high reset (count -> 0)
//   clear           load 1: the first alive cycle is cycle number 1
//   enable          advance the count by one
//   count           current alive-cycle number
//   limit_reached   count equals MAX_CYCLES
module mau_run_timer
    import mau_controller_pkg::*;
#(
    parameter logic [31:0] MAX_CYCLES = 32'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    output logic [31:0] count,
    output logic        limit_reached
);

    // Clear loads 1 rather than 0 because it fires on the accept edge, so the
    // value seen during the first alive cycle is already that cycle's number.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 32'd0;
        end else if (clear) begin
            count <= 32'd1;
        end else if (enable) begin
            count <= count + 32'd1;
        end
    end

    assign limit_reached = (count == MAX_CYCLES);

endmodule

// File: rtl/mau_controller.sv
// Host-side initiator for the CPU memory-access (MAU) interface. Converts a
// valid/ready command stream into MAU cycles on IM/DM/RF while the CPU is
// parked, and runs the CPU (alive=1) until halt or timeout.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (accepted only in IDLE)
//   cmd_op, cmd_target            op code and memory target
//   cmd_address, cmd_data         byte address and write data
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_err             read data / write echo / cycle count, error
//   mau_address, mau_write_data   shared MAU address and write data
//   mau_wren_im/dm/rf             per-memory write strobes
//   mau_read_data_im/dm/rf        per-memory read data
//   alive                         CPU run enable
//   halt                          CPU halt flag (valid while alive)
module mau_controller
    import mau_controller_pkg::*;
#(
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] MAX_CYCLES   = 32'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_target,
    input  logic [31:0] cmd_address,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] mau_address,
    output logic [31:0] mau_write_data,
    output logic        mau_wren_im,
    output logic        mau_wren_dm,
    output logic        mau_wren_rf,
    input  logic [31:0] mau_read_data_im,
    input  logic [31:0] mau_read_data_dm,
    input  logic [31:0] mau_read_data_rf,
    output logic        alive,
    input  logic        halt
);

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

    state_e           state, state_d;
    logic             alive_d;
    logic             rsp_valid_d;
    logic             rsp_err_d;
    logic [31:0]      rsp_data_d;
    logic [31:0]      mau_address_d;
    logic [31:0]      mau_write_data_d;
    logic [2:0]       wren_q, wren_d;
    logic [1:0]       target_q, target_d;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_d;
    logic [31:0]      last_count, last_count_d;
    logic             timer_clear;
    logic             timer_enable;
    logic [31:0]      cyc;
    logic             timer_limit;
    logic [31:0]      read_data_sel;

    mau_run_timer #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_run_timer (
        .clk           (clk),
        .rst           (rst),
        .clear         (timer_clear),
        .enable        (timer_enable),
        .count         (cyc),
        .limit_reached (timer_limit)
    );

    assign cmd_ready      = (state == ST_IDLE) & ~rst;
    assign mau_wren_im    = wren_q[0];
    assign mau_wren_dm    = wren_q[1];
    assign mau_wren_rf    = wren_q[2];

    // Pick the read port of the memory latched at accept time
    always_comb begin
        read_data_sel = mau_read_data_rf;
        case (target_q)
            TGT_IM:  read_data_sel = mau_read_data_im;
            TGT_DM:  read_data_sel = mau_read_data_dm;
            default: read_data_sel = mau_read_data_rf;
        endcase
    end

    // Next-state and next-output logic. Every output is registered, so the
    // values computed here appear one cycle later; strobes default to 0 so a
    // write strobe lasts exactly the single WRITE cycle.
    always_comb begin
        state_d          = state;
        alive_d          = alive;
        rsp_valid_d      = rsp_valid;
        rsp_err_d        = rsp_err;
        rsp_data_d       = rsp_data;
        mau_address_d    = mau_address;
        mau_write_data_d = mau_write_data;
        wren_d           = 3'b000;
        target_d         = target_q;
        lat_cnt_d        = lat_cnt;
        last_count_d     = last_count;
        timer_clear      = 1'b0;
        timer_enable     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    case (cmd_op)
                        OP_WRITE, OP_READ: begin
                            if (cmd_target == TGT_INVALID) begin
                                state_d     = ST_RSP;
                                rsp_valid_d = 1'b1;
                                rsp_data_d  = 32'd0;
                                rsp_err_d   = 1'b1;
                            end else begin
                                target_d      = cmd_target;
                                mau_address_d = cmd_address;
                                lat_cnt_d     = '0;
                                if (cmd_op == OP_WRITE) begin
                                    state_d          = ST_WRITE;
                                    mau_write_data_d = cmd_data;
                                    wren_d           = target_wren(cmd_target);
                                end else begin
                                    state_d = ST_READ;
                                end
                            end
                        end
                        OP_RUN: begin
                            // MAU lines go quiet while the CPU owns the memories
                            state_d          = ST_RUN;
                            alive_d          = 1'b1;
                            mau_address_d    = 32'd0;
                            mau_write_data_d = 32'd0;
                            timer_clear      = 1'b1;
                        end
                        default: begin
                            state_d     = ST_RSP;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = last_count;
                            rsp_err_d   = 1'b0;
                        end
                    endcase
                end
            end

            ST_WRITE: begin
                state_d     = ST_RSP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = mau_write_data;
                rsp_err_d   = 1'b0;
            end

            ST_READ: begin
                if (lat_cnt == LAT_LAST) begin
                    state_d     = ST_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = read_data_sel;
                    rsp_err_d   = 1'b0;
                end else begin
                    lat_cnt_d = lat_cnt + LAT_W'(1);
                end
            end

            ST_RUN: begin
                // Halt is checked first so a halt on the limit cycle is a success
                if (halt) begin
                    state_d      = ST_RSP;
                    alive_d      = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = cyc;
                    rsp_err_d    = 1'b0;
                    last_count_d = cyc;
                end else if (timer_limit) begin
                    state_d     = ST_RSP;
                    alive_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = MAX_CYCLES;
                    rsp_err_d   = 1'b1;
                end else begin
                    timer_enable = 1'b1;
                end
            end

            ST_RSP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset also drops alive on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            alive          <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_data       <= 32'd0;
            mau_address    <= 32'd0;
            mau_write_data <= 32'd0;
            wren_q         <= 3'b000;
            target_q       <= 2'd0;
            lat_cnt        <= '0;
            last_count     <= 32'd0;
        end else begin
            state          <= state_d;
            alive          <= alive_d;
            rsp_valid      <= rsp_valid_d;
            rsp_err        <= rsp_err_d;
            rsp_data       <= rsp_data_d;
            mau_address    <= mau_address_d;
            mau_write_data <= mau_write_data_d;
            wren_q         <= wren_d;
            target_q       <= target_d;
            lat_cnt        <= lat_cnt_d;
            last_count     <= last_count_d;
        end
    end

endmodule
